md4_round2_seq: RTL

- Iterative sequencer for MD4 round 2 (majority function G, constant 0x5A827999).
- Executes the 16 round-2 steps over one shared step datapath, one step per clock (two with the optional feature).
- Replaces the 16-instance unrolled round-2 array where area matters.
- Sits between the round-1 output registers and the round-3 input, using valid/ready handshakes on both sides.

---
 rtl/md4_pkg.sv | 30 +++
 rtl/md4_r2_step.sv | 26 ++
 rtl/md4_round2_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/md4_pkg.sv
// md4_pkg: shared constants, types and helpers for the MD4 round-2 sequencer.
//   K_R2      additive round-2 constant
//   R2_SHIFT  per-step rotate amounts, indexed by step mod 4
//   r2_word   message word index used by round-2 step i
//   rotl32    32-bit rotate left
package md4_pkg;

  localparam logic [31:0] K_R2 = 32'h5A827999;

  localparam logic [4:0] R2_SHIFT [0:3] = '{5'd3, 5'd5, 5'd9, 5'd13};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } r2_state_e;

  // k = 4*(i mod 4) + (i div 4) is a swap of the two index nibbles.
  function automatic logic [3:0] r2_word(input logic [3:0] i);
    return {i[1:0], i[3:2]};
  endfunction

  // Upper half of the doubled word shifted left is the rotation.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] w;
    w = {x, x} << s;
    return w[63:32];
  endfunction

endpackage

// File: rtl/md4_r2_step.sv
// md4_r2_step: one combinational MD4 round-2 step.
//   i_a..i_d  working words entering the step
//   i_xk      selected message word
//   i_s       rotate amount
//   o_t       rotl32(A + G(B,C,D) + Xk + K_R2, s)
module md4_r2_step
  import md4_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  input  logic [31:0] i_xk,
  input  logic [4:0]  i_s,
  output logic [31:0] o_t
);

  logic [31:0] w_g;
  logic [31:0] w_sum;

  // Bitwise majority of B, C, D.
  assign w_g   = (i_b & i_c) | (i_b & i_d) | (i_c & i_d);
  assign w_sum = i_a + w_g + i_xk + K_R2;
  assign o_t   = rotl32(w_sum, i_s);

endmodule

// File: rtl/md4_round2_seq.sv
// md4_round2_seq: iterative MD4 round-2 sequencer over a shared step datapath.
// Build option: define MD4_R2_TWO_STEP_EN to cascade two step instances and
// retire two steps per clock (8-cycle RUN instead of 16).
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     upstream handshake (ready only in IDLE)
//   a_in..d_in, x_in      chaining words and 512-bit message block
//   out_valid/out_ready   downstream handshake (valid only in DONE)
//   a_out..d_out          round-2 result, held until accepted
//   busy, step            RUN indicator and current step index
module md4_round2_seq
  import md4_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in,
  input  logic [511:0] x_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out,
  output logic         busy,
  output logic [3:0]   step
);

  r2_state_e         r_state;
  logic [3:0]        r_step;
  logic [31:0]       r_a, r_b, r_c, r_d;
  logic [15:0][31:0] r_x;
  logic [31:0]       r_ao, r_bo, r_co, r_do;

  logic [31:0] w_t0;
  logic [31:0] w_na, w_nb, w_nc, w_nd;

  md4_r2_step u_step0 (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_c  (r_c),
    .i_d  (r_d),
    .i_xk (r_x[r2_word(r_step)]),
    .i_s  (R2_SHIFT[r_step[1:0]]),
    .o_t  (w_t0)
  );

`ifdef MD4_R2_TWO_STEP_EN
  localparam logic [3:0] STEP_INC  = 4'd2;
  localparam logic [3:0] STEP_LAST = 4'd14;

  logic [3:0]  w_step1;
  logic [31:0] w_t1;

  // step is always even here, so i+1 never carries.
  assign w_step1 = r_step | 4'd1;

  // Second step sees the words after the first rotation: (D, T0, B, C).
  md4_r2_step u_step1 (
    .i_a  (r_d),
    .i_b  (w_t0),
    .i_c  (r_b),
    .i_d  (r_c),
    .i_xk (r_x[r2_word(w_step1)]),
    .i_s  (R2_SHIFT[w_step1[1:0]]),
    .o_t  (w_t1)
  );

  assign {w_na, w_nb, w_nc, w_nd} = {r_c, w_t1, w_t0, r_b};
`else
  localparam logic [3:0] STEP_INC  = 4'd1;
  localparam logic [3:0] STEP_LAST = 4'd15;

  assign {w_na, w_nb, w_nc, w_nd} = {r_d, w_t0, r_b, r_c};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_x     <= '0;
      r_ao    <= '0;
      r_bo    <= '0;
      r_co    <= '0;
      r_do    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_c     <= c_in;
            r_d     <= d_in;
            r_x     <= x_in;
            r_step  <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a <= w_na;
          r_b <= w_nb;
          r_c <= w_nc;
          r_d <= w_nd;
          if (r_step == STEP_LAST) begin
            // After a multiple of 4 steps the words are back in A,B,C,D order.
            r_ao    <= w_na;
            r_bo    <= w_nb;
            r_co    <= w_nc;
            r_do    <= w_nd;
            r_step  <= '0;
            r_state <= ST_DONE;
          end else begin
            r_step <= r_step + STEP_INC;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: begin
          r_step  <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode the state register only.
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_RUN);
  assign step      = r_step;
  assign a_out     = r_ao;
  assign b_out     = r_bo;
  assign c_out     = r_co;
  assign d_out     = r_do;

endmodule
